oup_ulpi_phy_responder: RTL
===========================

# oup_ulpi_phy_responder

PHY-side ULPI responder: the far end of the ULPI link that the OUP device controller drives. It accepts TX CMDs from the link, services register read/write with set/clear semantics, sinks transmit packets as a byte stream, and injects RX CMD bytes on request. It is used as the PHY model in the device-controller bench and as a PHY stand-in for FPGA loopback builds.

## Interface
- `NXT_DELAY`, 0: extra cycles nxt is held low after a TX CMD is first seen, before acceptance (0–15).
- `VENDOR_ID`, 16'h0424: returned at register addresses 0x00 (low byte) and 0x01 (high byte).
- `PRODUCT_ID`, 16'h0009: returned at register addresses 0x02 (low byte) and 0x03 (high byte).
- `ulpi_clk_i` in 1: the only clock; all logic is on its rising edge.
- `rst_i` in 1: asynchronous reset, active-high.
- `ulpi_data_io` inout 8: link drives it while dir=0; the block drives it only in the data cycles defined below, otherwise hi-Z.
- `ulpi_dir_o` out 1: bus direction; 1 means the PHY owns the bus.
- `ulpi_nxt_o` out 1: PHY accepts the current link byte.
- `ulpi_stp_i` in 1: link ends a register write or a transmit.
- `rx_cmd_req_i` in 1: request to send an RX CMD; level, held until ack.
- `rx_cmd_i` in 8: RX CMD byte, sampled in the turnaround cycle.
- `rx_cmd_ack_o` out 1: one-cycle pulse in the cycle the RX CMD is driven.
- `tx_start_o` out 1: pulse when a transmit TX CMD is accepted.
- `tx_pid_o` out 4: TX CMD[3:0], valid with `tx_start_o`.
- `tx_valid_o` out 1: one pulse per accepted transmit data byte.
- `tx_data_o` out 8: data byte, valid with `tx_valid_o`.
- `tx_end_o` out 1: pulse when stp terminates a transmit.
- `func_ctrl_o`, `iface_ctrl_o`, `otg_ctrl_o` out 8 each: current register values, for observation.

## Operation
- TX CMD decode on the link byte while dir=0:
  - 00: idle.
  - 01: transmit.
  - 10: RegWrite, address in [5:0].
  - 11: RegRead, address in [5:0].
- Register file, 6-bit address. Reads of any of the write/set/clear triple return the register value.
  - Function Control at 0x04 write, 0x05 set, 0x06 clear; reset value 0x41.
  - Interface Control at 0x07/0x08/0x09; reset value 0x00.
  - OTG Control at 0x0A/0x0B/0x0C; reset value 0x06.
  - Scratch at 0x16/0x17/0x18; reset value 0x00.
  - IDs at 0x00–0x03 are read-only.
  - All other addresses, including 0x2F (extended addressing, not supported), read 0x00 and ignore writes.
- Set ORs the data byte into the register. Clear ANDs the register with the inverted data byte.
- Function Control bit 5 (Reset): when a committed write leaves it at 1, all registers reload their defaults on the next cycle, and bit 5 reads 0.
- States: IDLE, WAIT, REGW_DATA, REGW_STP, REGR_TA, REGR_DATA, REGR_TA2, TX, RXC_DATA, RXC_TA2.
- Priority in IDLE: `rx_cmd_req_i` wins over a simultaneous non-zero link byte. The link's command is dropped and the link must reissue it.
- stp seen in IDLE is ignored.
- Async reset at any point:
  - State returns to IDLE; dir=0 and nxt=0; data goes hi-Z.
  - Registers take their defaults.
  - All pulse outputs go to 0.
  - An in-flight write is discarded.

## Timing
Cycle 0 below is the first cycle a non-zero TX CMD is on the bus. All outputs are registered.
- Acceptance:
  - The block waits NXT_DELAY cycles in WAIT.
  - nxt=1 in cycle 1+NXT_DELAY (call this cycle A). The command is accepted there.
  - If the link byte returns to 0x00 during WAIT, the block goes back to IDLE.
- RegWrite:
  - nxt=1 in A and A+1; the data byte is captured at the end of A+1.
  - In A+2 nxt=0 and stp must be 1. The write commits and the outputs reflect it from A+3.
  - If stp=0 in A+2, there is no write and the block returns to IDLE.
- RegRead:
  - A: nxt=1.
  - A+1: dir=1, bus hi-Z (turnaround).
  - A+2: dir=1, nxt=0, data = register value.
  - A+3: dir=0, hi-Z.
  - A+4: IDLE.
- Transmit:
  - A: nxt=1, and `tx_start_o` pulses in A+1.
  - From A+1, nxt=1 every cycle. Each byte present with nxt=1 and stp=0 yields `tx_valid_o` one cycle later.
  - The stp cycle carries no data. nxt=0 from the next cycle, and `tx_end_o` pulses one cycle after stp.
- RX CMD, with R the IDLE cycle where the request is seen:
  - R+1: dir=1, hi-Z (turnaround).
  - R+2: dir=1, nxt=0, data = `rx_cmd_i` latched in R+1, and `rx_cmd_ack_o`=1.
  - R+3: dir=0, hi-Z.
  - A still-asserted request is re-served from R+4.
- Reset values: `ulpi_dir_o`=0, `ulpi_nxt_o`=0, data hi-Z, all pulses 0, `tx_data_o`=0x00, `tx_pid_o`=0, registers at their defaults.

## Structure
- Package `oup_ulpi_pkg` holds:
  - the TX CMD type codes;
  - register address constants and reset values;
  - the state enum;
  - the set/clear address offsets.
  The device-controller ULPI state machine shares the same package.
- Sub-module `oup_ulpi_phy_regfile`:
  - inputs: address, write-data, write-enable, reset-bit handling;
  - outputs: read data and the three observation buses.
- Top level holds the FSM, the NXT_DELAY counter and the tristate driver.

## Test plan
- Reset then RegRead 0x00 and 0x01 → data cycles show 0x24 then 0x04; dir is high for exactly 2 cycles per read.
- RegWrite 0x16←0xA5, then 0x17←0x0F, then 0x18←0x81 → scratch reads 0xA5, 0xAF, 0x2E in turn; stp omitted on a fourth write → value unchanged.
- RegWrite 0x05←0x20 → `func_ctrl_o` 0x41 the cycle after commit, `otg_ctrl_o` 0x06, Function Control bit 5 reads 0.
- Transmit TX CMD 0x43 followed by 3 bytes then stp → `tx_start_o` with pid 3, `tx_valid_o` ×3 with matching bytes, one `tx_end_o`, nxt low after stp.
- `rx_cmd_req_i` with 0x4E in the same cycle as RegRead cmd 0xC4 → RX CMD 0x4E driven with ack; reissued read returns 0x41.
- NXT_DELAY=3, async reset asserted in the REGW_DATA state → dir/nxt low immediately, registers at defaults, the next command is accepted with 3 extra wait cycles.

Source files
------------

// File: rtl/oup_ulpi_pkg.sv
// Shared ULPI definitions for the OUP device controller and the PHY responder:
// TX CMD type codes, register map, reset values and the responder state type.
package oup_ulpi_pkg;

  // TX CMD type field, bits [7:6] of the link byte
  localparam logic [1:0] CMD_IDLE     = 2'b00;
  localparam logic [1:0] CMD_TRANSMIT = 2'b01;
  localparam logic [1:0] CMD_REGW     = 2'b10;
  localparam logic [1:0] CMD_REGR     = 2'b11;

  // Register map; writable registers occupy a write/set/clear triple
  localparam logic [5:0] ADDR_VENDOR_LO  = 6'h00;
  localparam logic [5:0] ADDR_VENDOR_HI  = 6'h01;
  localparam logic [5:0] ADDR_PRODUCT_LO = 6'h02;
  localparam logic [5:0] ADDR_PRODUCT_HI = 6'h03;
  localparam logic [5:0] ADDR_FUNC_CTRL  = 6'h04;
  localparam logic [5:0] ADDR_IFACE_CTRL = 6'h07;
  localparam logic [5:0] ADDR_OTG_CTRL   = 6'h0A;
  localparam logic [5:0] ADDR_SCRATCH    = 6'h16;

  // Offsets inside a triple
  localparam logic [5:0] OFS_WRITE = 6'd0;
  localparam logic [5:0] OFS_SET   = 6'd1;
  localparam logic [5:0] OFS_CLR   = 6'd2;

  localparam logic [7:0] FUNC_CTRL_RST  = 8'h41;
  localparam logic [7:0] IFACE_CTRL_RST = 8'h00;
  localparam logic [7:0] OTG_CTRL_RST   = 8'h06;
  localparam logic [7:0] SCRATCH_RST    = 8'h00;

  // Function Control bit that requests a full register reload
  localparam int FUNC_RESET_BIT = 5;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WAIT,
    ST_REGW_DATA,
    ST_REGW_STP,
    ST_REGR_TA,
    ST_REGR_DATA,
    ST_REGR_TA2,
    ST_TX,
    ST_RXC_DATA,
    ST_RXC_TA2
  } state_t;

  function automatic logic in_triple(input logic [5:0] addr, input logic [5:0] base);
    return (addr >= base) && (addr <= base + OFS_CLR);
  endfunction

  function automatic logic [7:0] apply_write(input logic [7:0] cur, input logic [7:0] data,
                                             input logic [5:0] ofs);
    case (ofs)
      OFS_WRITE: return data;
      OFS_SET:   return cur | data;
      OFS_CLR:   return cur & ~data;
      default:   return cur;
    endcase
  endfunction

endpackage

// File: rtl/oup_ulpi_phy_regfile.sv
// PHY register file: ID registers, three control registers and a scratch
// register with write/set/clear access, plus the Function Control reset bit.
module oup_ulpi_phy_regfile
  import oup_ulpi_pkg::*;
#(
  parameter logic [15:0] VENDOR_ID  = 16'h0424,
  parameter logic [15:0] PRODUCT_ID = 16'h0009
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] addr,
  input  logic [7:0] wdata,
  input  logic       we,
  output logic [7:0] rdata,
  output logic [7:0] func_ctrl,
  output logic [7:0] iface_ctrl,
  output logic [7:0] otg_ctrl
);

  logic [7:0] scratch;
  logic [7:0] func_new, iface_new, otg_new, scratch_new;

  // Post-write value of every register; registers not addressed keep their value
  always_comb begin
    func_new    = func_ctrl;
    iface_new   = iface_ctrl;
    otg_new     = otg_ctrl;
    scratch_new = scratch;
    if (we) begin
      if (in_triple(addr, ADDR_FUNC_CTRL))
        func_new = apply_write(func_ctrl, wdata, addr - ADDR_FUNC_CTRL);
      if (in_triple(addr, ADDR_IFACE_CTRL))
        iface_new = apply_write(iface_ctrl, wdata, addr - ADDR_IFACE_CTRL);
      if (in_triple(addr, ADDR_OTG_CTRL))
        otg_new = apply_write(otg_ctrl, wdata, addr - ADDR_OTG_CTRL);
      if (in_triple(addr, ADDR_SCRATCH))
        scratch_new = apply_write(scratch, wdata, addr - ADDR_SCRATCH);
    end
  end

  // Commit writes; a write that sets the reset bit reloads defaults instead, so the bit never reads 1
  always_ff @(posedge clk or posedge rst) begin
    if (rst || func_new[FUNC_RESET_BIT]) begin
      func_ctrl  <= FUNC_CTRL_RST;
      iface_ctrl <= IFACE_CTRL_RST;
      otg_ctrl   <= OTG_CTRL_RST;
      scratch    <= SCRATCH_RST;
    end else begin
      func_ctrl  <= func_new;
      iface_ctrl <= iface_new;
      otg_ctrl   <= otg_new;
      scratch    <= scratch_new;
    end
  end

  // Read mux; unmapped addresses (including extended addressing) read zero
  always_comb begin
    rdata = 8'h00;
    if (addr == ADDR_VENDOR_LO)                rdata = VENDOR_ID[7:0];
    else if (addr == ADDR_VENDOR_HI)           rdata = VENDOR_ID[15:8];
    else if (addr == ADDR_PRODUCT_LO)          rdata = PRODUCT_ID[7:0];
    else if (addr == ADDR_PRODUCT_HI)          rdata = PRODUCT_ID[15:8];
    else if (in_triple(addr, ADDR_FUNC_CTRL))  rdata = func_ctrl;
    else if (in_triple(addr, ADDR_IFACE_CTRL)) rdata = iface_ctrl;
    else if (in_triple(addr, ADDR_OTG_CTRL))   rdata = otg_ctrl;
    else if (in_triple(addr, ADDR_SCRATCH))    rdata = scratch;
  end

endmodule

// File: rtl/oup_ulpi_phy_responder.sv
// PHY-side ULPI responder: decodes TX CMDs, services register access,
// sinks transmit data and injects RX CMDs. All outputs are registered.
module oup_ulpi_phy_responder
  import oup_ulpi_pkg::*;
#(
  parameter int          NXT_DELAY  = 0,
  parameter logic [15:0] VENDOR_ID  = 16'h0424,
  parameter logic [15:0] PRODUCT_ID = 16'h0009
) (
  input  logic       ulpi_clk_i,
  input  logic       rst_i,
  inout  wire  [7:0] ulpi_data_io,
  output logic       ulpi_dir_o,
  output logic       ulpi_nxt_o,
  input  logic       ulpi_stp_i,
  input  logic       rx_cmd_req_i,
  input  logic [7:0] rx_cmd_i,
  output logic       rx_cmd_ack_o,
  output logic       tx_start_o,
  output logic [3:0] tx_pid_o,
  output logic       tx_valid_o,
  output logic [7:0] tx_data_o,
  output logic       tx_end_o,
  output logic [7:0] func_ctrl_o,
  output logic [7:0] iface_ctrl_o,
  output logic [7:0] otg_ctrl_o
);

  localparam logic [3:0] DELAY = 4'(NXT_DELAY);

  state_t     state, state_d;
  logic [3:0] cnt, cnt_d;
  logic       phase, phase_d;
  logic [7:0] cmd, cmd_d, wdata, wdata_d, dout, dout_d, tx_data_d, rdata;
  logic [3:0] tx_pid_d;
  logic       oe, oe_d, dir_d, nxt_d, reg_we;
  logic       rx_ack_d, tx_start_d, tx_valid_d, tx_end_d;

  // The PHY drives the bus only in its data cycles
  assign ulpi_data_io = oe ? dout : 8'hzz;

  oup_ulpi_phy_regfile #(.VENDOR_ID(VENDOR_ID), .PRODUCT_ID(PRODUCT_ID)) u_regfile (
    .clk        (ulpi_clk_i),
    .rst        (rst_i),
    .addr       (cmd[5:0]),
    .wdata      (wdata),
    .we         (reg_we),
    .rdata      (rdata),
    .func_ctrl  (func_ctrl_o),
    .iface_ctrl (iface_ctrl_o),
    .otg_ctrl   (otg_ctrl_o)
  );

  // Next state plus the values every registered output takes in the following cycle
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    phase_d    = phase;
    cmd_d      = cmd;
    wdata_d    = wdata;
    dout_d     = dout;
    tx_pid_d   = tx_pid_o;
    tx_data_d  = tx_data_o;
    dir_d      = 1'b0;
    nxt_d      = 1'b0;
    oe_d       = 1'b0;
    reg_we     = 1'b0;
    rx_ack_d   = 1'b0;
    tx_start_d = 1'b0;
    tx_valid_d = 1'b0;
    tx_end_d   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (rx_cmd_req_i) begin
          state_d = ST_RXC_DATA;
          phase_d = 1'b0;
          dir_d   = 1'b1;
        end else if (ulpi_data_io[7:6] != CMD_IDLE) begin
          state_d = ST_WAIT;
          cmd_d   = ulpi_data_io;
          cnt_d   = 4'd0;
          nxt_d   = (DELAY == 4'd0);
        end
      end
      ST_WAIT: begin
        if (ulpi_nxt_o) begin
          case (cmd[7:6])
            CMD_TRANSMIT: begin
              state_d    = ST_TX;
              nxt_d      = 1'b1;
              tx_start_d = 1'b1;
              tx_pid_d   = cmd[3:0];
            end
            CMD_REGW: begin
              state_d = ST_REGW_DATA;
              nxt_d   = 1'b1;
            end
            CMD_REGR: begin
              state_d = ST_REGR_TA;
              dir_d   = 1'b1;
            end
            default: state_d = ST_IDLE;
          endcase
        end else if (ulpi_data_io == 8'h00) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt + 4'd1;
          nxt_d = (cnt + 4'd1 == DELAY);
        end
      end
      ST_REGW_DATA: begin
        wdata_d = ulpi_data_io;
        state_d = ST_REGW_STP;
      end
      ST_REGW_STP: begin
        reg_we  = ulpi_stp_i;
        state_d = ST_IDLE;
      end
      ST_REGR_TA: begin
        state_d = ST_REGR_DATA;
        dir_d   = 1'b1;
        oe_d    = 1'b1;
        dout_d  = rdata;
      end
      ST_REGR_DATA: state_d = ST_REGR_TA2;
      ST_REGR_TA2:  state_d = ST_IDLE;
      ST_TX: begin
        if (ulpi_stp_i) begin
          state_d  = ST_IDLE;
          tx_end_d = 1'b1;
        end else begin
          nxt_d      = 1'b1;
          tx_valid_d = 1'b1;
          tx_data_d  = ulpi_data_io;
        end
      end
      ST_RXC_DATA: begin
        if (!phase) begin
          phase_d  = 1'b1;
          dir_d    = 1'b1;
          oe_d     = 1'b1;
          dout_d   = rx_cmd_i;
          rx_ack_d = 1'b1;
        end else begin
          state_d = ST_RXC_TA2;
        end
      end
      ST_RXC_TA2: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge ulpi_clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= ST_IDLE;
      cnt          <= 4'd0;
      phase        <= 1'b0;
      cmd          <= 8'h00;
      wdata        <= 8'h00;
      dout         <= 8'h00;
      oe           <= 1'b0;
      ulpi_dir_o   <= 1'b0;
      ulpi_nxt_o   <= 1'b0;
      rx_cmd_ack_o <= 1'b0;
      tx_start_o   <= 1'b0;
      tx_pid_o     <= 4'h0;
      tx_valid_o   <= 1'b0;
      tx_data_o    <= 8'h00;
      tx_end_o     <= 1'b0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      phase        <= phase_d;
      cmd          <= cmd_d;
      wdata        <= wdata_d;
      dout         <= dout_d;
      oe           <= oe_d;
      ulpi_dir_o   <= dir_d;
      ulpi_nxt_o   <= nxt_d;
      rx_cmd_ack_o <= rx_ack_d;
      tx_start_o   <= tx_start_d;
      tx_pid_o     <= tx_pid_d;
      tx_valid_o   <= tx_valid_d;
      tx_data_o    <= tx_data_d;
      tx_end_o     <= tx_end_d;
    end
  end

endmodule
